// File: rtl/rgb_to_gray_pipe.sv
// RGB to luma, 3-stage pipeline (multiply, partial sum, round+saturate); latency 3 clk when not stalled.
// Backpressure: one global enable stalls every stage at once; in_ready = !out_valid || out_ready.
module rgb_to_gray_pipe #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  in_r,
  input  logic [PIX_W-1:0]  in_g,
  input  logic [PIX_W-1:0]  in_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic              in_last,
  output logic [PIX_W-1:0]  out_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_last,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_mode,
  input  logic [COEF_W+1:0] cfg_cr,
  input  logic [COEF_W+1:0] cfg_cg,
  input  logic [COEF_W+1:0] cfg_cb,
  output logic              busy
);

  localparam int CW    = COEF_W + 2;
  localparam int PW    = PIX_W + CW;
  localparam int ACC_W = PIX_W + COEF_W + 4;

  function automatic logic [CW-1:0] coef_of(input longint unsigned num, input longint unsigned den);
    return CW'((num * (64'd1 << COEF_W) + den / 2) / den);
  endfunction

  localparam logic [CW-1:0] C601_R = coef_of(299, 1000);
  localparam logic [CW-1:0] C601_G = coef_of(587, 1000);
  localparam logic [CW-1:0] C601_B = coef_of(114, 1000);
  localparam logic [CW-1:0] C709_R = coef_of(2126, 10000);
  localparam logic [CW-1:0] C709_G = coef_of(7152, 10000);
  localparam logic [CW-1:0] C709_B = coef_of(722, 10000);
  localparam logic [CW-1:0] CAVG   = coef_of(1, 3);
  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (COEF_W - 1);

  logic          en, take_sof;
  logic [1:0]    mode_sh_q, mode_act_q, mode_use;
  logic [CW-1:0] cr_sh_q, cg_sh_q, cb_sh_q, cr_act_q, cg_act_q, cb_act_q;
  logic [CW-1:0] c_r, c_g, c_b;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign take_sof = in_valid && en && in_sof;

  // Shadow-to-active copy uses the pre-edge shadow, so a coincident cfg write lands only in shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_sh_q  <= 2'd0;
      mode_act_q <= 2'd0;
      cr_sh_q    <= '0;
      cg_sh_q    <= '0;
      cb_sh_q    <= '0;
      cr_act_q   <= '0;
      cg_act_q   <= '0;
      cb_act_q   <= '0;
    end else begin
      if (cfg_we) begin
        mode_sh_q <= cfg_mode;
        cr_sh_q   <= cfg_cr;
        cg_sh_q   <= cfg_cg;
        cb_sh_q   <= cfg_cb;
      end
      if (take_sof) begin
        mode_act_q <= mode_sh_q;
        cr_act_q   <= cr_sh_q;
        cg_act_q   <= cg_sh_q;
        cb_act_q   <= cb_sh_q;
      end
    end
  end

  // The sof pixel itself already sees the coefficients it is about to activate.
  always_comb begin
    mode_use = take_sof ? mode_sh_q : mode_act_q;
    c_r = C601_R;
    c_g = C601_G;
    c_b = C601_B;
    case (mode_use)
      2'd1: begin c_r = C709_R; c_g = C709_G; c_b = C709_B; end
      2'd2: begin
        c_r = take_sof ? cr_sh_q : cr_act_q;
        c_g = take_sof ? cg_sh_q : cg_act_q;
        c_b = take_sof ? cb_sh_q : cb_act_q;
      end
      2'd3: begin c_r = CAVG; c_g = CAVG; c_b = CAVG; end
      default: ;
    endcase
  end

  logic             s1_vld_q, s1_sof_q, s1_last_q;
  logic             s2_vld_q, s2_sof_q, s2_last_q;
  logic             s3_vld_q, s3_sof_q, s3_last_q;
  logic [PW-1:0]    p_r_q, p_g_q, p_b_q, p_b2_q;
  logic [PW-1:0]    p_r_d, p_g_d, p_b_d;
  logic [ACC_W-1:0] sum_rg_q, sum_rg_d, acc, acc_sh;
  logic [PIX_W-1:0] y_q, y_d;

  always_comb begin
    p_r_d    = PW'(in_r) * PW'(c_r);
    p_g_d    = PW'(in_g) * PW'(c_g);
    p_b_d    = PW'(in_b) * PW'(c_b);
    sum_rg_d = ACC_W'(p_r_q) + ACC_W'(p_g_q);
    acc      = sum_rg_q + ACC_W'(p_b2_q) + HALF;
    acc_sh   = acc >> COEF_W;
    y_d      = (|acc_sh[ACC_W-1:PIX_W]) ? {PIX_W{1'b1}} : acc_sh[PIX_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0; s1_sof_q <= 1'b0; s1_last_q <= 1'b0;
      s2_vld_q <= 1'b0; s2_sof_q <= 1'b0; s2_last_q <= 1'b0;
      s3_vld_q <= 1'b0; s3_sof_q <= 1'b0; s3_last_q <= 1'b0;
      p_r_q    <= '0;
      p_g_q    <= '0;
      p_b_q    <= '0;
      p_b2_q   <= '0;
      sum_rg_q <= '0;
      y_q      <= '0;
    end else if (en) begin
      s1_vld_q  <= in_valid;
      s1_sof_q  <= in_valid && in_sof;
      s1_last_q <= in_valid && in_last;
      p_r_q     <= p_r_d;
      p_g_q     <= p_g_d;
      p_b_q     <= p_b_d;
      s2_vld_q  <= s1_vld_q;
      s2_sof_q  <= s1_sof_q;
      s2_last_q <= s1_last_q;
      sum_rg_q  <= sum_rg_d;
      p_b2_q    <= p_b_q;
      s3_vld_q  <= s2_vld_q;
      s3_sof_q  <= s2_sof_q;
      s3_last_q <= s2_last_q;
      y_q       <= y_d;
    end
  end

  assign out_valid = s3_vld_q;
  assign out_sof   = s3_sof_q;
  assign out_last  = s3_last_q;
  assign out_y     = y_q;
  assign busy      = s1_vld_q || s2_vld_q || s3_vld_q;

endmodule
